bmp_slave_streamer: RTL and testbench
=====================================

# bmp_slave_streamer

- Initiator for one slave port of the image processing accelerator.
- Accepts a frame command (mode, process value, pixel count) and a stream of 24-bit pixels.
- Packs the pixels little-endian into 32-bit words and drives them onto the accelerator's `slv*` interface under the `slv_ready` handshake.
- Sits between a frame source (DMA/testbench/file reader) and `slv0_*` or `slv1_*` of the accelerator; one instance per slave port.

## Interface
- `DATA_WIDTH`, 32, slave data bus width; only 32 is supported, any other value is a compile-time error.
- `PIX_CNT_W`, 24, width of the frame pixel count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: frame start pulse; sampled only in IDLE.
- `cfg_mode` in 2: processing mode for the frame.
- `cfg_proc_val` in 8: processing value for the frame.
- `cfg_pix_count` in PIX_CNT_W: number of pixels in the frame.
- `pix_valid` in 1: upstream pixel valid.
- `pix_data` in 24: pixel, byte0=[7:0], byte1=[15:8], byte2=[23:16].
- `pix_ready` out 1: pixel accepted when `pix_valid && pix_ready`.
- `slv_mode` out 2: to accelerator `slvN_mode`.
- `slv_proc_val` out 8: to `slvN_proc_val`.
- `slv_data` out DATA_WIDTH: to `slvN_data`.
- `slv_data_valid` out 1: to `slvN_data_valid`.
- `slv_ready` in 1: from `slvN_ready`; a word transfers on a rising edge with `slv_data_valid && slv_ready`.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last word has transferred.

## Operation
- **Reset values:** all outputs 0, state IDLE.
- **States:** IDLE, SEND, FLUSH, DRAIN, DONE.
- **IDLE:**
  - On `start`: latch `cfg_mode` into `slv_mode`, `cfg_proc_val` into `slv_proc_val`, `cfg_pix_count` into `remaining`, clear the accumulator, then go to SEND.
  - `slv_mode` and `slv_proc_val` hold until the next accepted `start`.
  - `start` outside IDLE is ignored.
- **SEND:**
  - `pix_ready = (remaining != 0) && (!slv_data_valid || slv_ready)`.
  - On an accepted pixel: append its 3 bytes to the byte accumulator (holds 0–3 leftover bytes) and decrement `remaining`.
  - If the accumulator then holds ≥4 bytes: load the lowest 4 into `slv_data` (oldest byte at [7:0]), set `slv_data_valid`, and keep the remainder.
  - Pattern: every 4 pixels produce 3 words.
  - When `remaining == 0`: go to FLUSH if leftover > 0, else DRAIN.
- **FLUSH:**
  - When the output register is free (or draining this cycle), load the leftover bytes zero-padded in the upper bytes, then go to DRAIN.
- **DRAIN:** wait until `slv_data_valid` is low (last word taken), then go to DONE.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- **Word count:** ceil(3N/4).
- **Zero-pixel frame:** `cfg_pix_count == 0` goes SEND→DRAIN→DONE with no word sent.
- **`busy`:** 1 in every state except IDLE.
- **Mid-operation reset:** aborts the frame immediately. Partial data is discarded, all outputs return to 0, and no `done` is issued.

## Timing
- `start` sampled at edge T → `busy` = 1 and `pix_ready` eligible from T+1.
- A pixel accepted at edge T that completes a word → `slv_data_valid` = 1 from T+1. Latency is 1 cycle.
- Once `slv_data_valid` is asserted, `slv_data` is stable until the transfer edge. Valid never drops without a transfer.
- Transfer and new load may occur on the same edge. Valid stays high, data updates, and there is no bubble.
- Full throughput: 1 pixel per cycle while `slv_ready` = 1.
- Final word transferred at edge T → state DONE at T+1 with `done` = 1; IDLE and `busy` = 0 at T+2.
- `pix_ready` is combinational from `slv_ready`. There is no path from `slv_ready` to `slv_data_valid`.

## Configuration
- `BMP_TX_BGR_SWAP_EN`
  - Defined: swap `pix_data` bytes 0 and 2 before packing, converting BMP BGR to RGB order.
  - Undefined: bytes are packed exactly as received.
  - Handshake and timing are identical in both cases.

## Structure
- **Shared package `bmp_pkg`:**
  - constants `COLOR_SIZE` = 8 and `PIXEL_SIZE` = 24;
  - state enum `bmp_tx_state_t`;
  - mode encoding typedef `bmp_mode_t` (2 bits), shared with the accelerator.
- **Sub-module `bmp_byte_packer`:**
  - owns the 6-byte accumulator, leftover count, and zero-padded flush word;
  - exposes `word_rdy` and `word` to the top FSM.

## Test plan
- **4-pixel frame:** N=4, pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A, `slv_ready` = 1 → words 0x04030201, 0x08070605, 0x0C0B0A09, then `done` pulse.
- **5-pixel frame:** N=5, pixels as above plus 0x0F0E0D → 4 words, the last 0x000F0E0D; `slv_mode` and `slv_proc_val` equal the latched cfg values throughout.
- **Backpressure:** hold `slv_ready` = 0 for 5 cycles mid-frame → `slv_data` stable and `pix_ready` = 0 during the stall; no word lost or duplicated; total 3 words for N=4.
- **Zero-pixel frame:** N=0 → no `slv_data_valid`; `done` 3 cycles after `start`.
- **Reset mid-frame:** `rst_n` low after 2 words → all outputs 0 asynchronously. A new `start` with N=4 then yields the exact 3-word sequence.
- **BGR swap:** `BMP_TX_BGR_SWAP_EN` defined, N=4, pixels as in the 4-pixel frame → first word 0x06010203.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP slave-port streamer and the accelerator.
//   COLOR_SIZE / PIXEL_SIZE : byte and pixel widths in bits
//   WORD_BYTES / PIX_BYTES  : bytes per slave word and per pixel
//   bmp_mode_t              : 2-bit processing mode encoding
//   bmp_tx_state_t          : streamer FSM states
package bmp_pkg;

    localparam int COLOR_SIZE = 8;
    localparam int PIXEL_SIZE = 24;
    localparam int WORD_BYTES = 4;
    localparam int PIX_BYTES  = PIXEL_SIZE / COLOR_SIZE;

    typedef logic [1:0] bmp_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bmp_tx_state_t;

endpackage

// File: rtl/bmp_slave_streamer_if.sv
// Slave-port bus between the streamer and the accelerator (slvN_*).
// Handshake: a word transfers on a rising clock edge where
// slv_data_valid && slv_ready; once valid is raised, data and valid hold
// until that edge.
//   master : streamer side (drives mode, proc_val, data, data_valid)
//   slave  : accelerator side (drives slv_ready)
interface bmp_slave_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    import bmp_pkg::*;

    bmp_mode_t              slv_mode;
    logic [7:0]             slv_proc_val;
    logic [DATA_WIDTH-1:0]  slv_data;
    logic                   slv_data_valid;
    logic                   slv_ready;

    modport master (
        output slv_mode, slv_proc_val, slv_data, slv_data_valid,
        input  slv_ready
    );

    modport slave (
        input  slv_mode, slv_proc_val, slv_data, slv_data_valid,
        output slv_ready
    );

endinterface

// File: rtl/bmp_byte_packer.sv
// Byte accumulator that turns 3-byte pixels into 4-byte words.
//   clr        : empty the accumulator (frame start)
//   push       : a pixel is accepted this cycle
//   pix        : pixel bytes, byte0 = [7:0] is the oldest
//   take_flush : the zero-padded leftover word is consumed this cycle
//   word_rdy   : this push completes a word (combinational)
//   word       : the completed word, oldest byte at [7:0]
//   flush_word : leftover bytes, upper bytes zero
//   lo_cnt     : number of leftover bytes (0..3)
module bmp_byte_packer
    import bmp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  push,
    input  logic [PIXEL_SIZE-1:0] pix,
    input  logic                  take_flush,
    output logic                  word_rdy,
    output logic [31:0]           word,
    output logic [31:0]           flush_word,
    output logic [1:0]            lo_cnt
);

    // Leftover bytes sit at the bottom; bytes above lo_cnt are kept zero so
    // the merge below is a plain OR and the flush word needs no masking.
    logic [23:0] lo_q;
    logic [1:0]  cnt_q;
    logic [47:0] merged;

    always_comb begin
        merged = {24'b0, lo_q} | ({24'b0, pix} << {cnt_q, 3'b000});
    end

    // 3 new bytes reach a full word whenever at least one byte was waiting.
    assign word_rdy   = push && (cnt_q != 2'd0);
    assign word       = merged[31:0];
    assign flush_word = {8'b0, lo_q};
    assign lo_cnt     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q  <= '0;
            cnt_q <= '0;
        end else if (clr || take_flush) begin
            lo_q  <= '0;
            cnt_q <= '0;
        end else if (push) begin
            if (cnt_q != 2'd0) begin
                lo_q  <= {8'b0, merged[47:32]};
                cnt_q <= cnt_q - 2'd1;
            end else begin
                lo_q  <= merged[23:0];
                cnt_q <= 2'd3;
            end
        end
    end

endmodule

// File: rtl/bmp_slave_streamer.sv
// Frame initiator for one accelerator slave port. Latches a frame command,
// accepts 24-bit pixels, packs them little-endian into 32-bit words and
// drives them onto the slave bus; done pulses once the last word is taken.
// Optional build macro: BMP_TX_BGR_SWAP_EN swaps pixel bytes 0 and 2
// (BGR -> RGB) before packing; handshake and timing are unchanged.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start, cfg_mode,
//   cfg_proc_val, cfg_pix_count: frame command, sampled in IDLE only
//   pix_valid, pix_data,
//   pix_ready                  : pixel stream (transfer on valid && ready)
//   slv                        : slave bus (master modport)
//   busy, done                 : frame in progress / end-of-frame pulse
//   state_dbg                  : current FSM state
module bmp_slave_streamer
    import bmp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PIX_CNT_W  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  bmp_mode_t             cfg_mode,
    input  logic [7:0]            cfg_proc_val,
    input  logic [PIX_CNT_W-1:0]  cfg_pix_count,
    input  logic                  pix_valid,
    input  logic [PIXEL_SIZE-1:0] pix_data,
    output logic                  pix_ready,
    bmp_slave_streamer_if.master  slv,
    output logic                  busy,
    output logic                  done,
    output bmp_tx_state_t         state_dbg
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("bmp_slave_streamer: DATA_WIDTH must be 32");
        end
    endgenerate

    bmp_tx_state_t          state_q, state_d;
    bmp_mode_t              mode_q;
    logic [7:0]             proc_val_q;
    logic [PIX_CNT_W-1:0]   remaining_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_q;

    logic                   out_free;
    logic                   accept;
    logic                   start_acc;
    logic                   load;
    logic [DATA_WIDTH-1:0]  load_word;
    logic                   pk_clr;
    logic                   pk_take;
    logic                   pk_word_rdy;
    logic [31:0]            pk_word;
    logic [31:0]            pk_flush_word;
    logic [1:0]             pk_lo_cnt;
    logic [PIXEL_SIZE-1:0]  pix_in;

`ifdef BMP_TX_BGR_SWAP_EN
    assign pix_in = {pix_data[7:0], pix_data[15:8], pix_data[23:16]};
`else
    assign pix_in = pix_data;
`endif

    // The output register can take a new word if empty or emptying this edge.
    assign out_free = !valid_q || slv.slv_ready;

    bmp_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pk_clr),
        .push       (accept),
        .pix        (pix_in),
        .take_flush (pk_take),
        .word_rdy   (pk_word_rdy),
        .word       (pk_word),
        .flush_word (pk_flush_word),
        .lo_cnt     (pk_lo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        pix_ready = 1'b0;
        accept    = 1'b0;
        start_acc = 1'b0;
        load      = 1'b0;
        load_word = '0;
        pk_clr    = 1'b0;
        pk_take   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    pk_clr    = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                pix_ready = (remaining_q != '0) && out_free;
                accept    = pix_valid && pix_ready;
                if (accept && pk_word_rdy) begin
                    load      = 1'b1;
                    load_word = pk_word;
                end
                if (remaining_q == '0) begin
                    state_d = (pk_lo_cnt != 2'd0) ? ST_FLUSH : ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_word = pk_flush_word;
                    pk_take   = 1'b1;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the last word goes, so DONE follows the
                // transfer edge directly.
                if (out_free) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            proc_val_q  <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                mode_q      <= cfg_mode;
                proc_val_q  <= cfg_proc_val;
                remaining_q <= cfg_pix_count;
            end else if (accept) begin
                remaining_q <= remaining_q - PIX_CNT_W'(1);
            end
            if (load) begin
                data_q <= load_word;
            end
            // Valid only drops on a transfer edge with nothing new to load.
            valid_q <= load || (valid_q && !slv.slv_ready);
        end
    end

    assign slv.slv_mode       = mode_q;
    assign slv.slv_proc_val   = proc_val_q;
    assign slv.slv_data       = data_q;
    assign slv.slv_data_valid = valid_q;
    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_bmp_slave_streamer.sv
module tb_bmp_slave_streamer;
    import bmp_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    bmp_mode_t     cfg_mode = '0;
    logic [7:0]    cfg_proc_val = '0;
    logic [23:0]   cfg_pix_count = '0;
    logic          pix_valid = 1'b0;
    logic [23:0]   pix_data = '0;
    logic          pix_ready;
    logic          busy;
    logic          done;
    bmp_tx_state_t state_dbg;

    bmp_slave_streamer_if #(.DATA_WIDTH(32)) slv_if ();

    bmp_slave_streamer #(.DATA_WIDTH(32), .PIX_CNT_W(24)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .cfg_mode      (cfg_mode),
        .cfg_proc_val  (cfg_proc_val),
        .cfg_pix_count (cfg_pix_count),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .slv           (slv_if.master),
        .busy          (busy),
        .done          (done),
        .state_dbg     (state_dbg)
    );

`ifdef BMP_TX_BGR_SWAP_EN
    localparam logic [31:0] W0 = 32'h06010203;
    localparam logic [31:0] W1 = 32'h08090405;
    localparam logic [31:0] W2 = 32'h0A0B0C07;
    localparam logic [31:0] W5 = 32'h000D0E0F;
`else
    localparam logic [31:0] W0 = 32'h04030201;
    localparam logic [31:0] W1 = 32'h08070605;
    localparam logic [31:0] W2 = 32'h0C0B0A09;
    localparam logic [31:0] W5 = 32'h000F0E0D;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          xfer_cnt = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          stall_left = 0;
    bit          ready_rand = 1'b0;
    bit          rand_gaps = 1'b0;
    logic [23:0] pix_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bmp_mode_t   exp_mode = '0;
    logic [7:0]  exp_pv = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Byte stream of the frame, cut into 4-byte little-endian words,
    // last partial word zero-padded.
    task automatic model_frame();
        logic [7:0]  bq[$];
        logic [23:0] p;
        logic [31:0] w;
        foreach (pix_q[i]) begin
            p = pix_q[i];
`ifdef BMP_TX_BGR_SWAP_EN
            p = {p[7:0], p[15:8], p[23:16]};
`endif
            bq.push_back(p[7:0]);
            bq.push_back(p[15:8]);
            bq.push_back(p[23:16]);
            while (bq.size() >= 4) begin
                w = {bq[3], bq[2], bq[1], bq[0]};
                repeat (4) void'(bq.pop_front());
                exp_q.push_back(w);
            end
        end
        if (bq.size() > 0) begin
            w = '0;
            for (int k = 0; k < bq.size(); k++) w[8*k +: 8] = bq[k];
            exp_q.push_back(w);
        end
    endtask

    // ---------------- slave-side ready driver ----------------
    always begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            slv_if.slv_ready = 1'b0;
            stall_left--;
        end else if (ready_rand) begin
            slv_if.slv_ready = ($urandom_range(0, 3) != 0);
        end else begin
            slv_if.slv_ready = 1'b1;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 32'(slv_if.slv_data_valid), 32'd1);
                check("stall_data_hold", slv_if.slv_data, prev_data);
            end
            if (slv_if.slv_data_valid) valid_cnt++;
            if (slv_if.slv_data_valid && !slv_if.slv_ready)
                check("pix_ready_in_stall", 32'(pix_ready), 32'd0);
            if (slv_if.slv_data_valid && slv_if.slv_ready) begin
                xfer_cnt++;
                got_q.push_back(slv_if.slv_data);
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("word", slv_if.slv_data, exp_q.pop_front());
                end
                check("slv_mode", 32'(slv_if.slv_mode), 32'(exp_mode));
                check("slv_proc_val", 32'(slv_if.slv_proc_val), 32'(exp_pv));
            end
            if (done) done_cnt++;
            prev_stall = slv_if.slv_data_valid && !slv_if.slv_ready;
            prev_data  = slv_if.slv_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_pixels();
        int waited;
        foreach (pix_q[i]) begin
            if (rand_gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    pix_valid = 1'b0;
                    pix_data  = 24'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            pix_valid = 1'b1;
            pix_data  = pix_q[i];
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!pix_ready && waited < 200);
            if (!pix_ready) begin
                check("pix_timeout", 32'(pix_ready), 32'd1);
                pix_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done();
        int waited = 0;
        while (done_cnt == 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", 32'(done_cnt != 0), 32'd1);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
    endtask

    // Launch a frame of n pixels (fixed pattern 0x030201, 0x060504, ... or random).
    task automatic launch(input int n, input bit fixed);
        pix_q.delete();
        got_q.delete();
        for (int i = 0; i < n; i++) begin
            if (fixed) pix_q.push_back({8'(3*i+3), 8'(3*i+2), 8'(3*i+1)});
            else       pix_q.push_back(24'($urandom));
        end
        model_frame();
        done_cnt  = 0;
        xfer_cnt  = 0;
        valid_cnt = 0;
        exp_mode  = 2'($urandom);
        exp_pv    = 8'($urandom);
        cfg_mode      = exp_mode;
        cfg_proc_val  = exp_pv;
        cfg_pix_count = 24'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble the command inputs; the latched values must hold.
        cfg_mode      = 2'($urandom);
        cfg_proc_val  = 8'($urandom);
        cfg_pix_count = 24'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic run_frame(input int n, input bit fixed);
        launch(n, fixed);
        drive_pixels();
        wait_done();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        slv_if.slv_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(slv_if.slv_data_valid), 32'd0);
        check("rst_data", slv_if.slv_data, 32'd0);
        check("rst_mode", 32'(slv_if.slv_mode), 32'd0);
        check("rst_proc_val", 32'(slv_if.slv_proc_val), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 4-pixel frame, full throughput
        run_frame(4, 1'b1);
        check("f4_words", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("f4_w0", got_q[0], W0);
            check("f4_w1", got_q[1], W1);
            check("f4_w2", got_q[2], W2);
        end

        // 5-pixel frame with random ready
        ready_rand = 1'b1;
        run_frame(5, 1'b1);
        ready_rand = 1'b0;
        check("f5_words", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) check("f5_last", got_q[3], W5);

        // Backpressure: 5-cycle stall mid-frame, plus a start that must be ignored
        fork
            begin
                repeat (5) @(posedge clk);
                stall_left = 5;
                @(posedge clk);
                #1;
                start = 1'b1;
                cfg_pix_count = 24'd99;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join_none
        run_frame(4, 1'b1);
        check("bp_words", 32'(got_q.size()), 32'd3);

        // Zero-pixel frame
        launch(0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        check("zero_done_latency", 32'(lat), 32'd3);
        @(negedge clk);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_valid_cnt", 32'(valid_cnt), 32'd0);
        check("zero_xfer_cnt", 32'(xfer_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-frame after 2 words
        launch(8, 1'b1);
        pix_valid = 1'b1;
        pix_data  = pix_q[0];
        for (int i = 1; i < 8; i++) pix_q[i] = pix_q[0];
        exp_q.delete();
        model_frame();
        lat = 0;
        while (xfer_cnt < 2 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("rst_mid_words", 32'(xfer_cnt >= 2), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(slv_if.slv_data_valid), 32'd0);
        check("mid_rst_data", slv_if.slv_data, 32'd0);
        check("mid_rst_mode", 32'(slv_if.slv_mode), 32'd0);
        check("mid_rst_proc_val", 32'(slv_if.slv_proc_val), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
        exp_q.delete();
        pix_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(4, 1'b1);
        check("post_rst_words", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("post_rst_w0", got_q[0], W0);
            check("post_rst_w1", got_q[1], W1);
            check("post_rst_w2", got_q[2], W2);
        end

        // Randomized frames
        ready_rand = 1'b1;
        rand_gaps  = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(1, 40), 1'b0);
            check("rand_word_count", 32'(got_q.size()), 32'((3 * pix_q.size() + 3) / 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
